led_sequencer: RTL and testbench
================================

# led_sequencer

Autonomous LED pattern generator that sits directly upstream of the LED bank and drives its 12-bit instruction port. It accepts a small command set on its own 12-bit instruction interface (mode, period, seed, run/stop). While running, it advances an 8-bit pattern once per programmable period and emits one LDI instruction per step, so the bank displays rotate, blink or bounce animations without processor involvement.

## Interface
- PERIOD_WIDTH, 16: width of period register and countdown counter.
- clock  in  1  system clock; all state updates on rising edge.
- reset  in  1  synchronous, active-high.
- inst  in  12  command; [11:8] opcode, [7:0] immediate.
- inst_en  in  1  command valid, one command per cycle it is high.
- out_inst  out  12  instruction to LED bank; always {4'h1 (LDI), pattern} when valid.
- out_inst_en  out  1  one-cycle valid strobe for out_inst.
- running  out  1  high while in Running state.
- error  out  1  high while in Error state.

## Operation
- Command opcodes: 0 NOP; 1 STP (stop); 2 RUN, imm[1:0] = mode; 3 PRL, period[7:0] = imm; 4 PRH, period[15:8] = imm (bits above PERIOD_WIDTH-1 ignored); 5 SED, pattern = imm. Opcodes 6-F → Error.
- Modes: 0 rotate left, 1 rotate right, 2 blink (pattern = ~pattern), 3 bounce (see Configuration).
- States: Reset → Idle (unconditional, one cycle); Idle --RUN--> Running; Running --STP--> Idle; Running --RUN--> Running (restart); any --illegal opcode or illegal mode--> Error; Error sticky until reset. Commands are ignored in Reset.
- NOP, PRL, PRH, SED are legal in Idle and Running; state unchanged.
- RUN: latch mode, set bounce direction to left, load counter with period, emit current pattern unmodified.
- Tick: in Running, when counter == 0 → step pattern per mode, emit the stepped pattern, reload counter with period; else decrement counter.
- Rotate: 8-bit circular shift by 1. Pattern 8'h00 or 8'hFF stays constant; still emitted each tick.
- STP: no emission; pattern, period, mode retained.
- SED while Running: pattern replaced; no immediate emission; next tick emits step(new pattern).
- PRL/PRH while Running: take effect at next reload; current countdown not disturbed.
- inst_en in same cycle as tick: command processed, tick suppressed (counter holds its value, no step); RUN restart overrides both.
- Reset values: out_inst = 12'h000, out_inst_en = 0, running = 0, error = 0, pattern = 8'h01, period = all ones, mode = 0, counter = 0, direction = left.
- Entering Error: out_inst_en stays 0; no further emissions.

## Timing
- All outputs registered.
- Command sampled at rising edge ending cycle t; for RUN, out_inst_en = 1 in cycle t+1.
- Emissions spaced exactly period+1 cycles while undisturbed; period = 0 → one emission every cycle.
- running/error reflect the new state in cycle t+1.
- reset asserted mid-run: out_inst_en = 0 from the next cycle; one Reset cycle, then Idle.

## Configuration
- LED_SEQUENCER_BOUNCE_EN defined: mode 3 is bounce. Moving left: if pattern[7] is set, direction flips to right and pattern >> 1; else pattern << 1. Moving right: mirrored on pattern[0]. Zero-fill shifts. Seed 8'h01 yields 01,02,…,80,40,…,01,02.
- LED_SEQUENCER_BOUNCE_EN undefined: RUN with mode 3 is illegal → Error. Direction logic is absent.

## Test plan
- Reset, PRL 0x03, PRH 0x00, RUN mode 0 → LDI 01 one cycle after RUN, then 02, 04, 08 at 4-cycle spacing, 80→01 wrap.
- SED 0xA5, period 0, RUN mode 2 → emissions A5, 5A, A5 on consecutive cycles.
- Running mode 1, seed 01, period 2; STP → no emission after STP; RUN → LDI 01 next cycle, counter restarted.
- Opcode 0x7 while Running → error = 1, running = 0, no emissions; reset → error = 0, Idle after 2 cycles.
- Bounce build: seed 01, period 0, RUN 3 → 01,02,…,80,40,…,01,02. Non-bounce build: RUN 3 → error = 1.
- PRL issued in the tick cycle → no step that cycle, next emission one cycle late, new period applied at following reload.

Source files
------------

// File: rtl/led_sequencer.sv
// led_sequencer: autonomous LED animation engine driving the LED bank's 12-bit LDI port.
// Latency: RUN emits the current pattern next cycle; steps emit every period+1 cycles.
// Optional bounce animation (mode 3) is compiled in when LED_SEQUENCER_BOUNCE_EN is defined.
module led_sequencer #(
  parameter int PERIOD_WIDTH = 16
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [11:0] inst,
  input  logic        inst_en,
  output logic [11:0] out_inst,
  output logic        out_inst_en,
  output logic        running,
  output logic        error
);

  typedef enum logic [1:0] {
    ST_RESET,
    ST_IDLE,
    ST_RUNNING,
    ST_ERROR
  } state_t;

  localparam logic [3:0] OP_NOP = 4'h0;
  localparam logic [3:0] OP_STP = 4'h1;
  localparam logic [3:0] OP_RUN = 4'h2;
  localparam logic [3:0] OP_PRL = 4'h3;
  localparam logic [3:0] OP_PRH = 4'h4;
  localparam logic [3:0] OP_SED = 4'h5;
  localparam logic [3:0] OP_LDI = 4'h1;

  state_t                  state;
  logic [7:0]              pattern;
  logic [PERIOD_WIDTH-1:0] period;
  logic [PERIOD_WIDTH-1:0] counter;
  logic [1:0]              mode;
  logic [7:0]              step_pattern;
  logic                    mode_legal;

  logic [3:0] opcode;
  logic [7:0] imm;
  assign opcode = inst[11:8];
  assign imm    = inst[7:0];

`ifdef LED_SEQUENCER_BOUNCE_EN
  // Bounce direction: 0 = moving left, 1 = moving right.
  logic dir_right;
  logic step_dir_right;
  assign mode_legal = 1'b1;
`else
  assign mode_legal = (imm[1:0] != 2'd3);
`endif

  // Next pattern (and bounce direction) for one animation step in the current mode.
  always_comb begin
    step_pattern = pattern;
`ifdef LED_SEQUENCER_BOUNCE_EN
    step_dir_right = dir_right;
`endif
    case (mode)
      2'd0: step_pattern = {pattern[6:0], pattern[7]};
      2'd1: step_pattern = {pattern[0], pattern[7:1]};
      2'd2: step_pattern = ~pattern;
      2'd3: begin
`ifdef LED_SEQUENCER_BOUNCE_EN
        if (!dir_right) begin
          if (pattern[7]) begin
            step_dir_right = 1'b1;
            step_pattern   = pattern >> 1;
          end else begin
            step_pattern   = pattern << 1;
          end
        end else begin
          if (pattern[0]) begin
            step_dir_right = 1'b0;
            step_pattern   = pattern << 1;
          end else begin
            step_pattern   = pattern >> 1;
          end
        end
`else
        step_pattern = pattern;
`endif
      end
    endcase
  end

  // Control FSM: command decode, period countdown and registered LDI emission.
  always_ff @(posedge clock) begin
    if (reset) begin
      state       <= ST_RESET;
      out_inst    <= 12'h000;
      out_inst_en <= 1'b0;
      running     <= 1'b0;
      error       <= 1'b0;
      pattern     <= 8'h01;
      period      <= '1;
      mode        <= 2'd0;
      counter     <= '0;
`ifdef LED_SEQUENCER_BOUNCE_EN
      dir_right   <= 1'b0;
`endif
    end else begin
      out_inst_en <= 1'b0;
      case (state)
        ST_RESET: state <= ST_IDLE;
        ST_IDLE, ST_RUNNING: begin
          if (inst_en) begin
            // A command in the tick cycle suppresses the tick: counter holds at zero.
            if (state == ST_RUNNING && counter != '0)
              counter <= counter - PERIOD_WIDTH'(1);
            case (opcode)
              OP_NOP: ;
              OP_STP: begin
                if (state == ST_RUNNING) begin
                  state   <= ST_IDLE;
                  running <= 1'b0;
                end
              end
              OP_RUN: begin
                if (mode_legal) begin
                  state       <= ST_RUNNING;
                  running     <= 1'b1;
                  mode        <= imm[1:0];
                  counter     <= period;
                  out_inst    <= {OP_LDI, pattern};
                  out_inst_en <= 1'b1;
`ifdef LED_SEQUENCER_BOUNCE_EN
                  dir_right   <= 1'b0;
`endif
                end else begin
                  state   <= ST_ERROR;
                  running <= 1'b0;
                  error   <= 1'b1;
                end
              end
              OP_PRL: period <= (period & ~PERIOD_WIDTH'(8'hFF)) | PERIOD_WIDTH'(imm);
              OP_PRH: period <= (period & ~PERIOD_WIDTH'(16'hFF00)) | PERIOD_WIDTH'({imm, 8'h00});
              OP_SED: pattern <= imm;
              default: begin
                state   <= ST_ERROR;
                running <= 1'b0;
                error   <= 1'b1;
              end
            endcase
          end else if (state == ST_RUNNING) begin
            if (counter == '0) begin
              pattern     <= step_pattern;
              out_inst    <= {OP_LDI, step_pattern};
              out_inst_en <= 1'b1;
              counter     <= period;
`ifdef LED_SEQUENCER_BOUNCE_EN
              dir_right   <= step_dir_right;
`endif
            end else begin
              counter <= counter - PERIOD_WIDTH'(1);
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_led_sequencer.sv
// tb_led_sequencer: directed and random command streams against a tick-time reference model.
// The model tracks the absolute edge index of the next step instead of a countdown.
// Outputs are sampled 1 time unit after each rising edge.
module tb_led_sequencer;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic [11:0] inst = 12'h000;
  logic        inst_en = 1'b0;
  logic [11:0] out_inst;
  logic        out_inst_en;
  logic        running;
  logic        error;

  led_sequencer #(.PERIOD_WIDTH(16)) dut (
    .clock      (clock),
    .reset      (reset),
    .inst       (inst),
    .inst_en    (inst_en),
    .out_inst   (out_inst),
    .out_inst_en(out_inst_en),
    .running    (running),
    .error      (error)
  );

  always #5 clock = ~clock;

  int checks = 0;
  int failures = 0;

  // Reference model state. phase: 0 reset cycle, 1 idle, 2 running, 3 error.
  int m_phase = 0;
  int m_pat = 1;
  int m_per = 65535;
  int m_mode = 0;
  int m_dir = 1;       // +1 moving left, -1 moving right
  int n = 0;           // index of the current rising edge
  int next_tick = 0;   // edge index at which the next step happens
  bit exp_en = 0;
  int exp_pat = 0;
  bit bounce_en;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_step();
    case (m_mode)
      0: m_pat = ((m_pat << 1) | (m_pat >> 7)) & 255;
      1: m_pat = ((m_pat >> 1) | (m_pat << 7)) & 255;
      2: m_pat = 255 - m_pat;
      default: begin
        if (m_dir == 1) begin
          if (m_pat & 128) begin m_dir = -1; m_pat = m_pat >> 1; end
          else m_pat = (m_pat << 1) & 255;
        end else begin
          if (m_pat & 1) begin m_dir = 1; m_pat = (m_pat << 1) & 255; end
          else m_pat = m_pat >> 1;
        end
      end
    endcase
  endtask

  task automatic model_edge(input bit rst, input bit en, input int op, input int imm);
    exp_en = 0;
    if (rst) begin
      m_phase = 0; m_pat = 1; m_per = 65535; m_mode = 0; m_dir = 1;
    end else if (m_phase == 0) begin
      m_phase = 1;
    end else if (m_phase == 1 || m_phase == 2) begin
      if (en) begin
        bit was_tick;
        was_tick = (m_phase == 2) && (n == next_tick);
        case (op)
          0: ;
          1: if (m_phase == 2) m_phase = 1;
          2: begin
            if ((imm % 4) == 3 && !bounce_en) m_phase = 3;
            else begin
              m_phase = 2; m_mode = imm % 4; m_dir = 1;
              next_tick = n + m_per + 1;
              exp_en = 1; exp_pat = m_pat;
            end
          end
          3: m_per = (m_per & 'hFF00) | imm;
          4: m_per = (m_per & 'h00FF) | (imm << 8);
          5: m_pat = imm;
          default: m_phase = 3;
        endcase
        if (m_phase == 2 && op != 2 && was_tick) next_tick = n + 1;
      end else if (m_phase == 2 && n == next_tick) begin
        model_step();
        exp_en = 1; exp_pat = m_pat;
        next_tick = n + m_per + 1;
      end
    end
    n++;
  endtask

  task automatic check_outputs();
    check("out_inst_en", out_inst_en, exp_en);
    if (exp_en) check("out_inst", out_inst, 32'h100 | exp_pat);
    check("running", running, m_phase == 2);
    check("error", error, m_phase == 3);
  endtask

  task automatic cyc(input bit en, input int op, input int imm);
    logic [3:0] op4;
    logic [7:0] imm8;
    op4 = op[3:0];
    imm8 = imm[7:0];
    inst_en = en;
    inst = {op4, imm8};
    @(posedge clock);
    model_edge(1'b0, en, op, imm);
    #1;
    check_outputs();
  endtask

  task automatic idle(input int k);
    for (int i = 0; i < k; i++) cyc(1'b0, 0, 0);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    inst_en = 1'b0;
    @(posedge clock);
    model_edge(1'b1, 1'b0, 0, 0);
    #1;
    check_outputs();
    check("reset_out_inst", out_inst, 32'h000);
    reset = 1'b0;
  endtask

  initial begin
`ifdef LED_SEQUENCER_BOUNCE_EN
    bounce_en = 1;
`else
    bounce_en = 0;
`endif
    // Reset, then a RUN during the Reset cycle must be ignored.
    do_reset();
    cyc(1'b1, 2, 0);
    // Rotate left with period 3: 01 then 02, 04, ... at 4-cycle spacing, wrap 80 -> 01.
    cyc(1'b1, 3, 3);
    cyc(1'b1, 4, 0);
    cyc(1'b1, 2, 0);
    idle(36);
    // PRL landing in a tick cycle: step suppressed, new period at next reload.
    cyc(1'b1, 2, 0);
    idle(3);
    cyc(1'b1, 3, 1);
    idle(10);
    // Blink with period 0: A5, 5A, A5 on consecutive cycles.
    cyc(1'b1, 5, 'hA5);
    cyc(1'b1, 3, 0);
    cyc(1'b1, 2, 2);
    idle(5);
    // Rotate right, period 2, stop then restart.
    cyc(1'b1, 5, 1);
    cyc(1'b1, 3, 2);
    cyc(1'b1, 2, 1);
    idle(7);
    cyc(1'b1, 1, 0);
    idle(5);
    cyc(1'b1, 2, 1);
    idle(4);
    // Illegal opcode while running -> sticky error, cleared by reset.
    cyc(1'b1, 7, 0);
    idle(3);
    do_reset();
    idle(2);
    // Mode 3: bounce sequence, or error when bounce is not built in.
    cyc(1'b1, 5, 1);
    cyc(1'b1, 3, 0);
    cyc(1'b1, 2, 3);
    idle(18);
    do_reset();
    idle(1);
    cyc(1'b1, 3, 1);
    cyc(1'b1, 4, 0);
    // Random command stream.
    for (int it = 0; it < 500; it++) begin
      int r, k, op, imm;
      bit en;
      r = $urandom_range(0, 99);
      if (m_phase == 3 && r < 30) begin
        do_reset();
      end else begin
        en = ($urandom_range(0, 2) == 0);
        k = $urandom_range(0, 99);
        imm = $urandom_range(0, 255);
        if (k < 3) op = $urandom_range(6, 15);
        else if (k < 18) begin
          op = 2;
          if (bounce_en) imm = $urandom_range(0, 3);
          else imm = ($urandom_range(0, 9) == 0) ? 3 : $urandom_range(0, 2);
        end
        else if (k < 28) op = 1;
        else if (k < 43) begin op = 3; imm = $urandom_range(0, 4); end
        else if (k < 48) begin op = 4; imm = 0; end
        else if (k < 63) op = 5;
        else op = 0;
        cyc(en, op, imm);
      end
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
